fc_mac_sequencer: RTL and testbench
===================================

Name: fc_mac_sequencer

Overview:
Downstream consumer of the FC activation register file. It walks the register file's combinational read port to fetch INPUT_SIZE activations and consumes a streamed weight vector per neuron. It performs signed multiply-accumulate for OUTPUT_SIZE neurons and emits one accumulated result per neuron over a valid/ready output stream. The block is the compute stage between the register file and the FC result buffer.

Parameters:
BITWIDTH, 8, signed width of activations and weights
INPUT_SIZE, 7, activations per neuron (1..32)
OUTPUT_SIZE, 5, neurons per start (1..32)
ACT_BASE, 0, register-file address of activation 0; ACT_BASE+INPUT_SIZE <= 32
ACC_W, 2*BITWIDTH+$clog2(INPUT_SIZE), accumulator/result width (derived localparam)

Ports:
clk_i  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start_i  in  1  start-of-layer pulse
busy_o  out  1  high from accepted start until done
done_o  out  1  one-cycle pulse after the last result handshake
rd_addr_o  out  5  register-file read address
rd_data_i  in  BITWIDTH  activation from the register file, same cycle (combinational read)
w_valid_i  in  1  weight valid
w_data_i  in  BITWIDTH  signed weight, row-major (neuron o, input i)
w_ready_o  out  1  weight accepted when valid and ready
y_valid_o  out  1  result valid
y_ready_i  in  1  downstream ready
y_data_o  out  ACC_W  signed neuron result
y_idx_o  out  5  neuron index of y_data_o

Behaviour:
- One clock (clk_i, rising edge). Reset is asynchronous and active-low (reset_n).
- Reset values: state IDLE, counters 0, acc 0. All outputs 0: busy_o, done_o, w_ready_o, y_valid_o, y_data_o, y_idx_o, and rd_addr_o = ACT_BASE.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - start_i = 1 -> MAC, with o = 0, i = 0, acc = 0, busy_o = 1.
  - start_i while busy_o = 1 is ignored.
- MAC:
  - rd_addr_o = ACT_BASE + i. w_ready_o = 1.
  - On a weight handshake: acc += sext(rd_data_i * w_data_i), both operands signed, product 2*BITWIDTH bits sign-extended to ACC_W. Then i++.
  - No handshake: acc and i hold.
  - Handshake with i == INPUT_SIZE-1 -> OUT (acc includes the final product).
- OUT:
  - y_valid_o = 1, y_data_o = acc, y_idx_o = o. w_ready_o = 0.
  - Outputs are stable while y_ready_i = 0.
  - On handshake with o == OUTPUT_SIZE-1 -> IDLE. busy_o falls and done_o pulses on the next cycle.
  - On handshake otherwise: o++, i = 0, acc = 0 -> MAC.
- Latency: with weights always valid and y_ready_i tied high, each neuron takes INPUT_SIZE+1 cycles. The final handshake is OUTPUT_SIZE*(INPUT_SIZE+1) cycles after the start edge. done_o follows one cycle later.
- Overflow cannot occur: ACC_W covers INPUT_SIZE worst-case products (-2^(B-1))^2.
- Register-file writes during MAC are not guarded. The activation sampled is whatever rd_data_i shows at the handshake edge.
- Reset mid-operation: immediate return to IDLE, partial results discarded, no done_o.

Optional Feature:
FC_RELU_EN.
- Defined: y_data_o = (acc < 0) ? 0 : acc, applied at OUT.
- Undefined: raw signed acc.
- Timing and handshakes are identical in both cases.

Decomposition:
- Package fc_pkg:
  - FSM state encoding localparams (IDLE/MAC/OUT)
  - clog2 helper and the ACC_W derivation
  - register-file address width constant (5)
- Natural sub-module fc_mac_unit:
  - signed BITWIDTH x BITWIDTH multiply, sign-extend, accumulate into ACC_W
  - clear and enable inputs

Test Plan:
1. Activations all 1, weights all 2, y_ready_i = 1, default params.
   - Results idx 0..4 all = 14.
   - Final handshake 40 cycles after start; done_o at cycle 41.
2. Activations all -128, weights all -128.
   - Each result = 114688, no wrap in 19 bits.
3. Weight bubbles: w_valid_i low every other cycle.
   - Same results as scenario 1; total cycles 75.
   - acc holds during bubbles.
4. y_ready_i low 3 cycles at idx 2.
   - y_valid_o, y_data_o and y_idx_o stable; no weight accepted; resume correctly.
5. Activations 1, weights -1.
   - Result -7 without FC_RELU_EN; 0 with it defined.
6. Assert reset_n low mid-MAC at neuron 3.
   - Outputs return to reset values asynchronously; no done_o.
   - A fresh start reproduces scenario 1 exactly; start_i while busy is ignored.

Source files
------------

// File: rtl/fc_pkg.sv
// fc_pkg: shared FSM encoding, address width and accumulator sizing for the FC MAC sequencer.
package fc_pkg;
  localparam logic [1:0] S_IDLE = 2'd0, S_MAC = 2'd1, S_OUT = 2'd2;
  localparam int AW = 5;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int acc_width(input int bw, input int n);
    return 2 * bw + clog2(n);
  endfunction
endpackage

// File: rtl/fc_mac_unit.sv
// fc_mac_unit: signed multiply, sign-extend and accumulate with clear and enable.
module fc_mac_unit #(
  parameter int BITWIDTH = 8,
  parameter int ACC_W = 19
) (
  input  logic                       clk_i,
  input  logic                       reset_n,
  input  logic                       clr_i,
  input  logic                       en_i,
  input  logic signed [BITWIDTH-1:0] a_i,
  input  logic signed [BITWIDTH-1:0] b_i,
  output logic signed [ACC_W-1:0]    acc_o
);
  logic signed [2*BITWIDTH-1:0] prod;
  assign prod = a_i * b_i;
  always_ff @(posedge clk_i or negedge reset_n)
    if (!reset_n) acc_o <= '0;
    else acc_o <= clr_i ? '0 : en_i ? acc_o + ACC_W'(prod) : acc_o;
endmodule

// File: rtl/fc_mac_sequencer.sv
// fc_mac_sequencer: fetches activations from the register file, MACs streamed weights per neuron,
// and streams one result per neuron; define FC_RELU_EN to clamp negative results to zero.
module fc_mac_sequencer
  import fc_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int INPUT_SIZE = 7,
  parameter int OUTPUT_SIZE = 5,
  parameter int ACT_BASE = 0,
  localparam int ACC_W = acc_width(BITWIDTH, INPUT_SIZE)
) (
  input  logic                       clk_i,
  input  logic                       reset_n,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [AW-1:0]              rd_addr_o,
  input  logic signed [BITWIDTH-1:0] rd_data_i,
  input  logic                       w_valid_i,
  input  logic signed [BITWIDTH-1:0] w_data_i,
  output logic                       w_ready_o,
  output logic                       y_valid_o,
  input  logic                       y_ready_i,
  output logic signed [ACC_W-1:0]    y_data_o,
  output logic [AW-1:0]              y_idx_o
);
  logic [1:0] state;
  logic [AW-1:0] o, i;
  logic signed [ACC_W-1:0] acc;
  logic go, w_hs, y_hs, last_i, last_o;
  assign go = state == S_IDLE && start_i;
  assign w_hs = state == S_MAC && w_valid_i;
  assign y_hs = state == S_OUT && y_ready_i;
  assign last_i = i == AW'(INPUT_SIZE - 1);
  assign last_o = o == AW'(OUTPUT_SIZE - 1);
  fc_mac_unit #(.BITWIDTH(BITWIDTH), .ACC_W(ACC_W)) u_mac (
    .clk_i(clk_i),
    .reset_n(reset_n),
    .clr_i(go || (y_hs && !last_o)),
    .en_i(w_hs),
    .a_i(rd_data_i),
    .b_i(w_data_i),
    .acc_o(acc)
  );
  always_ff @(posedge clk_i or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      o <= '0;
      i <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= y_hs && last_o;
      if (go) begin
        state <= S_MAC;
        o <= '0;
        i <= '0;
      end else if (w_hs) begin
        state <= last_i ? S_OUT : S_MAC;
        i <= last_i ? '0 : i + 1'b1;
      end else if (y_hs) begin
        state <= last_o ? S_IDLE : S_MAC;
        o <= last_o ? '0 : o + 1'b1;
      end
    end
  assign busy_o = state != S_IDLE;
  assign w_ready_o = state == S_MAC;
  assign y_valid_o = state == S_OUT;
  assign rd_addr_o = w_ready_o ? AW'(ACT_BASE) + i : AW'(ACT_BASE);
  assign y_idx_o = y_valid_o ? o : '0;
`ifdef FC_RELU_EN
  assign y_data_o = (y_valid_o && !acc[ACC_W-1]) ? acc : '0;
`else
  assign y_data_o = y_valid_o ? acc : '0;
`endif
endmodule

// File: tb/tb_fc_mac_sequencer.sv
// tb_fc_mac_sequencer: table vectors, randomized layers vs a sum-of-products model, stall and reset sequences.
module tb_fc_mac_sequencer;
  localparam int BW = 8, IN = 7, ON = 5, BASE = 0;
  localparam int ACC_W = 2 * BW + $clog2(IN);
`ifdef FC_RELU_EN
  localparam longint NEG_Y = 0;
`else
  localparam longint NEG_Y = -7;
`endif
  logic clk_i = 0, reset_n = 0, start_i = 0, w_valid_i = 0, y_ready_i = 0;
  logic busy_o, done_o, w_ready_o, y_valid_o;
  logic [4:0] rd_addr_o, y_idx_o;
  logic signed [BW-1:0] rd_data_i, w_data_i = 0;
  logic signed [ACC_W-1:0] y_data_o;
  logic signed [BW-1:0] act [32];
  logic signed [BW-1:0] wt [ON][IN];
  longint exp_y [ON];
  int vecs = 0, errs = 0;

  typedef struct {
    int a;
    int w;
    longint y;
    int bubble;
    int stall;
    int cyc;
  } vec_t;
  vec_t tbl [5];

  always #5 clk_i = ~clk_i;
  assign rd_data_i = act[rd_addr_o];

  fc_mac_sequencer #(.BITWIDTH(BW), .INPUT_SIZE(IN), .OUTPUT_SIZE(ON), .ACT_BASE(BASE)) dut (
    .clk_i(clk_i),
    .reset_n(reset_n),
    .start_i(start_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data_i),
    .w_valid_i(w_valid_i),
    .w_data_i(w_data_i),
    .w_ready_o(w_ready_o),
    .y_valid_o(y_valid_o),
    .y_ready_i(y_ready_i),
    .y_data_o(y_data_o),
    .y_idx_o(y_idx_o)
  );

  task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic longint ref_y(input int o);
    longint s = 0;
    for (int i = 0; i < IN; i++) s += longint'(act[BASE+i]) * longint'(wt[o][i]);
`ifdef FC_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic fill(input int a, input int w);
    for (int j = 0; j < 32; j++) act[j] = BW'(a);
    for (int o = 0; o < ON; o++)
      for (int i = 0; i < IN; i++) wt[o][i] = BW'(w);
  endtask

  task automatic run_layer(input int bubble, input int rnd, input int stall_idx, input int exp_cyc, input int busy_start);
    int k = 0, n = 0, cyc = 0, stall = 0, ph = 0;
    logic hw, hy;
    @(negedge clk_i);
    start_i = 1;
    @(posedge clk_i);
    while (n < ON && cyc < 3000) begin
      @(negedge clk_i);
      start_i = busy_start != 0 && cyc == 5;
      w_valid_i = rnd != 0 ? 1'($urandom_range(0, 1)) : bubble != 0 ? (w_ready_o && ph != 0) : 1'b1;
      ph = w_ready_o ? 1 - ph : 0;
      w_data_i = k < IN * ON ? wt[k/IN][k%IN] : '0;
      y_ready_i = rnd != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (y_valid_o && int'(y_idx_o) == stall_idx && stall < 3) begin
        y_ready_i = 0;
        stall++;
      end
      chk("busy_during_layer", busy_o, 1);
      if (y_valid_o) begin
        chk("y_data", y_data_o, exp_y[n]);
        chk("y_idx", y_idx_o, n);
        chk("w_ready_in_out", w_ready_o, 0);
      end else if (w_ready_o) chk("rd_addr", rd_addr_o, BASE + k % IN);
      hw = w_valid_i && w_ready_o;
      hy = y_valid_o && y_ready_i;
      @(posedge clk_i);
      cyc++;
      if (hw) k++;
      if (hy) n++;
    end
    chk("results_within_budget", n, ON);
    chk("weights_consumed", k, IN * ON);
    if (exp_cyc != 0) chk("final_hs_cycle", cyc, exp_cyc);
    @(negedge clk_i);
    start_i = 0;
    chk("done_pulse", done_o, 1);
    chk("busy_after_layer", busy_o, 0);
    @(negedge clk_i);
    chk("done_clear", done_o, 0);
  endtask

  initial begin
    tbl[0] = '{1, 2, 14, 0, -1, 40};
    tbl[1] = '{-128, -128, 114688, 0, -1, 40};
    tbl[2] = '{1, 2, 14, 1, -1, 75};
    tbl[3] = '{1, 2, 14, 0, 2, 43};
    tbl[4] = '{1, -1, NEG_Y, 0, -1, 40};
    fill(0, 0);
    @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_w_ready", w_ready_o, 0);
    chk("rst_y_valid", y_valid_o, 0);
    chk("rst_y_data", y_data_o, 0);
    chk("rst_y_idx", y_idx_o, 0);
    chk("rst_rd_addr", rd_addr_o, BASE);
    reset_n = 1;
    for (int t = 0; t < 5; t++) begin
      fill(tbl[t].a, tbl[t].w);
      for (int o = 0; o < ON; o++) exp_y[o] = tbl[t].y;
      run_layer(tbl[t].bubble, 0, tbl[t].stall, tbl[t].cyc, 0);
    end
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 32; j++) act[j] = BW'($urandom);
      for (int o = 0; o < ON; o++)
        for (int i = 0; i < IN; i++) wt[o][i] = BW'($urandom);
      for (int o = 0; o < ON; o++) exp_y[o] = ref_y(o);
      run_layer(0, 1, -1, 0, 0);
    end
    fill(1, 2);
    @(negedge clk_i);
    w_valid_i = 1;
    y_ready_i = 1;
    w_data_i = 2;
    start_i = 1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 0;
    repeat (26) @(posedge clk_i);
    @(negedge clk_i);
    chk("pre_reset_busy", busy_o, 1);
    reset_n = 0;
    #1;
    chk("async_busy", busy_o, 0);
    chk("async_w_ready", w_ready_o, 0);
    chk("async_y_valid", y_valid_o, 0);
    chk("async_y_data", y_data_o, 0);
    chk("async_y_idx", y_idx_o, 0);
    chk("async_rd_addr", rd_addr_o, BASE);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("no_done_in_reset", done_o, 0);
    end
    reset_n = 1;
    @(negedge clk_i);
    chk("no_done_after_reset", done_o, 0);
    chk("idle_after_reset", busy_o, 0);
    for (int o = 0; o < ON; o++) exp_y[o] = 14;
    run_layer(0, 0, -1, 40, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
